// File: rtl/night_rider_pkg.sv
// Shared constants and helpers for the night-rider LED scanner family.
package night_rider_pkg;

    localparam logic [1:0] MODE_BOUNCE    = 2'b00;
    localparam logic [1:0] MODE_WRAP_UP   = 2'b01;
    localparam logic [1:0] MODE_WRAP_DOWN = 2'b10;
    localparam logic [1:0] MODE_FILL      = 2'b11;

    // Width of a position index into an n-wide bar; never less than one bit.
    function automatic int unsigned pos_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nr_prescaler.sv
// Programmable step prescaler: one-cycle step every div+1 enabled cycles.
module nr_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Step fires when the enabled counter reaches the live reload value.
    always_comb begin
        step  = en && (cnt_q == div);
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = '0;
        end else if (en) begin
            // A div lowered below cnt lets the counter wrap through its full range.
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register, held while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/night_rider_scanner.sv
// N-wide LED scanner with bounce, wrap-up, wrap-down and fill modes plus a trailing tail.
module night_rider_scanner
    import night_rider_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned TRAIL = 1,
    parameter int unsigned DIV_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [DIV_W-1:0]        div,
    output logic [N-1:0]            led_out,
    output logic [pos_width(N)-1:0] pos,
    output logic                    dir,
    output logic                    cycle_done
);

    localparam int unsigned     PW     = pos_width(N);
    localparam logic [PW-1:0]   PosMax = PW'(N - 1);
    localparam logic [PW-1:0]   PosOne = PW'(1);

    logic          step;
    logic [PW-1:0] pos_q, pos_d;
    logic          dir_q, dir_d;
    logic [N-1:0]  led_q, led_d;
    logic          done_q, done_d;
    logic [31:0]   pos_ext;

    nr_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .div  (div),
        .step (step)
    );

    // Next position, direction and end-of-period flag for the current mode.
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        done_d = 1'b0;
        unique case (mode)
            MODE_WRAP_UP: begin
                dir_d = 1'b1;
                if (pos_q == PosMax) begin
                    pos_d  = '0;
                    done_d = 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
            MODE_WRAP_DOWN: begin
                dir_d = 1'b0;
                if (pos_q == '0) begin
                    pos_d  = PosMax;
                    done_d = 1'b1;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end
            MODE_BOUNCE, MODE_FILL: begin
                // Endpoints override dir so a stale direction from another mode self-corrects.
                if (pos_q == PosMax) begin
                    pos_d = PosMax - 1'b1;
                    dir_d = 1'b0;
                end else if (pos_q == '0) begin
                    pos_d = PosOne;
                    dir_d = 1'b1;
                end else if (dir_q) begin
                    pos_d = pos_q + 1'b1;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
                if (pos_d == PosMax) begin
                    dir_d = 1'b0;
                end else if (pos_d == '0) begin
                    dir_d = 1'b1;
                end
                done_d = (pos_q == PosOne) && (pos_d == '0);
            end
        endcase
    end

    // LED mask from the next head position; the tail is clipped at both ends.
    always_comb begin
        led_d   = '0;
        pos_ext = 32'(pos_d);
        for (int unsigned i = 0; i < N; i++) begin
            if (mode == MODE_FILL) begin
                led_d[i] = (i <= pos_ext);
            end else if (dir_d) begin
                led_d[i] = (i <= pos_ext) && (i + TRAIL > pos_ext);
            end else begin
                led_d[i] = (i >= pos_ext) && (i < pos_ext + TRAIL);
            end
        end
    end

    // Scanner state advances only on prescaler steps; the done pulse lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= '0;
            dir_q  <= 1'b1;
            led_q  <= N'(1);
            done_q <= 1'b0;
        end else begin
            done_q <= step && done_d;
            if (step) begin
                pos_q <= pos_d;
                dir_q <= dir_d;
                led_q <= led_d;
            end
        end
    end

    assign led_out    = led_q;
    assign pos        = pos_q;
    assign dir        = dir_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_night_rider_scanner.sv
// Scoreboard bench for night_rider_scanner across several N/TRAIL configurations.
module tb_night_rider_scanner;
    import night_rider_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [1:0]  mode  = MODE_BOUNCE;
    logic [15:0] div   = '0;

    // 0: N=8 TRAIL=1, 1: N=8 TRAIL=3, 2: N=5 TRAIL=1, 3: N=6 TRAIL=1
    logic [7:0] a_led, b_led;
    logic [4:0] c_led;
    logic [5:0] d_led;
    logic [2:0] a_pos, b_pos, c_pos, d_pos;
    logic       a_dir, b_dir, c_dir, d_dir;
    logic       a_done, b_done, c_done, d_done;

    night_rider_scanner #(.N(8), .TRAIL(1), .DIV_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div),
        .led_out(a_led), .pos(a_pos), .dir(a_dir), .cycle_done(a_done)
    );
    night_rider_scanner #(.N(8), .TRAIL(3), .DIV_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div),
        .led_out(b_led), .pos(b_pos), .dir(b_dir), .cycle_done(b_done)
    );
    night_rider_scanner #(.N(5), .TRAIL(1), .DIV_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div),
        .led_out(c_led), .pos(c_pos), .dir(c_dir), .cycle_done(c_done)
    );
    night_rider_scanner #(.N(6), .TRAIL(1), .DIV_W(16)) dut_d (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div),
        .led_out(d_led), .pos(d_pos), .dir(d_dir), .cycle_done(d_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    id;
        int    pos;
        bit    dir;
        int    led;
        bit    done;
        string tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Hand-computed sequences (step k = index+1 after reset).
    int bp [14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    bit bd [14] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int bl3[14] = '{'h03, 'h07, 'h0E, 'h1C, 'h38, 'h70, 'h80,
                    'hC0, 'hE0, 'h70, 'h38, 'h1C, 'h0E, 'h01};
    int fp [8]  = '{1, 2, 3, 4, 3, 2, 1, 0};
    bit fd [8]  = '{1, 1, 1, 0, 0, 0, 0, 1};
    int fl [8]  = '{'h03, 'h07, 'h0F, 'h1F, 'h0F, 'h07, 'h03, 'h01};
    int wp [7]  = '{5, 4, 3, 2, 1, 0, 5};

    task automatic push(input int id, input int c, input int p, input bit d, input int l,
                        input bit dn, input string tag);
        exp_t e;
        e.cyc = c; e.id = id; e.pos = p; e.dir = d; e.led = l; e.done = dn; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic do_reset(input logic [1:0] m, input int d, output int c0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = m;
        div   = 16'(d);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0    = cyc;
    endtask

    // Called at posedge+1; returns at posedge+1 of cycle c.
    task automatic wait_to(input int c);
        repeat (c - cyc) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, required 0", q.size());
            bad++;
            q.delete();
        end
    endtask

    // Monitor: pop every expectation due this cycle and compare on the falling edge.
    exp_t me;
    int   gp, gl;
    bit   gd, gdn;
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                me = q.pop_front();
                case (me.id)
                    0:       begin gp = int'(a_pos); gl = int'(a_led); gd = a_dir; gdn = a_done; end
                    1:       begin gp = int'(b_pos); gl = int'(b_led); gd = b_dir; gdn = b_done; end
                    2:       begin gp = int'(c_pos); gl = int'(c_led); gd = c_dir; gdn = c_done; end
                    default: begin gp = int'(d_pos); gl = int'(d_led); gd = d_dir; gdn = d_done; end
                endcase
                total++;
                if (me.cyc != cyc || gp != me.pos || gd != me.dir || gl != me.led ||
                    gdn != me.done) begin
                    bad++;
                    $display("FAIL %s dut%0d cyc=%0d: got pos=%0d dir=%0d led=%h done=%0d, required pos=%0d dir=%0d led=%h done=%0d (due cyc %0d)",
                             me.tag, me.id, cyc, gp, gd, gl, gdn, me.pos, me.dir, me.led,
                             me.done, me.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;

        // Bounce, div=0: TRAIL=1 and TRAIL=3 instances run in parallel.
        do_reset(MODE_BOUNCE, 0, c0);
        push(0, c0, 0, 1'b1, 'h01, 1'b0, "reset_a");
        push(1, c0, 0, 1'b1, 'h01, 1'b0, "reset_b");
        for (int k = 0; k < 14; k++) begin
            push(0, c0 + k + 1, bp[k], bd[k], 1 << bp[k], k == 13, "bounce_t1");
            push(1, c0 + k + 1, bp[k], bd[k], bl3[k], k == 13, "bounce_t3");
        end
        push(0, c0 + 15, 1, 1'b1, 'h02, 1'b0, "bounce_restart");
        drain();

        // Wrap-up, div=3: step every 4 cycles, pulse on 7 -> 0.
        do_reset(MODE_WRAP_UP, 3, c0);
        for (int c = 0; c <= 36; c++) begin
            push(0, c0 + c, (c / 4) % 8, 1'b1, 1 << ((c / 4) % 8), c == 32, "wrap_up_div3");
        end
        drain();

        // Fill on N=5.
        do_reset(MODE_FILL, 0, c0);
        push(2, c0, 0, 1'b1, 'h01, 1'b0, "fill_reset");
        for (int k = 0; k < 8; k++) begin
            push(2, c0 + k + 1, fp[k], fd[k], fl[k], k == 7, "fill_n5");
        end
        drain();

        // Wrap-down on N=6: 0 -> 5, never 6 or 7.
        do_reset(MODE_WRAP_DOWN, 0, c0);
        push(3, c0, 0, 1'b1, 'h01, 1'b0, "wdown_reset");
        for (int k = 0; k < 7; k++) begin
            push(3, c0 + k + 1, wp[k], 1'b0, 1 << wp[k], k == 0 || k == 6, "wdown_n6");
        end
        drain();

        // Wrap-up to pos 7, then switch to bounce.
        do_reset(MODE_WRAP_UP, 0, c0);
        for (int k = 0; k <= 7; k++) begin
            push(0, c0 + k, k, 1'b1, 1 << k, 1'b0, "mode_sw_pre");
        end
        push(0, c0 + 8, 6, 1'b0, 'h40, 1'b0, "mode_sw_bounce");
        push(0, c0 + 9, 5, 1'b0, 'h20, 1'b0, "mode_sw_bounce2");
        wait_to(c0 + 7);
        mode = MODE_BOUNCE;
        drain();

        // Enable low for 10 cycles mid-period with div=2.
        do_reset(MODE_BOUNCE, 2, c0);
        for (int c = 0; c < 20; c++) begin
            int p;
            p = (c < 3) ? 0 : (c < 16) ? 1 : (c < 19) ? 2 : 3;
            push(0, c0 + c, p, 1'b1, 1 << p, 1'b0, "pause");
        end
        wait_to(c0 + 4);
        en = 1'b0;
        wait_to(c0 + 14);
        en = 1'b1;
        drain();

        // Asynchronous reset at pos=4, dir=0 (frozen first so no clock edge masks it).
        do_reset(MODE_BOUNCE, 0, c0);
        push(0, c0, 0, 1'b1, 'h01, 1'b0, "areset_pre0");
        for (int k = 0; k < 10; k++) begin
            push(0, c0 + k + 1, bp[k], bd[k], 1 << bp[k], 1'b0, "areset_pre");
        end
        push(0, c0 + 11, 0, 1'b1, 'h01, 1'b0, "areset_now");
        push(0, c0 + 12, 0, 1'b1, 'h01, 1'b0, "areset_held");
        push(0, c0 + 13, 1, 1'b1, 'h02, 1'b0, "areset_resume");
        wait_to(c0 + 10);
        en = 1'b0;
        wait_to(c0 + 11);
        rst_n = 1'b0;
        wait_to(c0 + 12);
        rst_n = 1'b1;
        en    = 1'b1;
        drain();

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
